// File: rtl/chess_clock_ctrl_if.sv
// Signal bundle between the chess clock controller, its buttons, the two
// countdown timers and the display logic.
interface chess_clock_ctrl_if #(
  parameter int MOVE_CNT_W = 8
);
  logic                  btn_start;
  logic                  btn_reset;
  logic                  btn_p1;
  logic                  btn_p2;
  logic                  btn_pause;
  logic                  zero1;
  logic                  zero2;
  logic                  start;
  logic                  player;
  logic                  timer_reset;
  logic                  game_over;
  logic [1:0]            winner;
  logic [MOVE_CNT_W-1:0] move_count;

  modport master (
    input  btn_start, btn_reset, btn_p1, btn_p2, btn_pause, zero1, zero2,
    output start, player, timer_reset, game_over, winner, move_count
  );

  modport slave (
    output btn_start, btn_reset, btn_p1, btn_p2, btn_pause, zero1, zero2,
    input  start, player, timer_reset, game_over, winner, move_count
  );
endinterface

// File: rtl/chess_clock_ctrl.sv
// Chess clock game controller: button synchronize/debounce plus turn FSM.
// Optional pause feature is built when CHESS_PAUSE_EN is defined.
module chess_clock_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int MOVE_CNT_W = 8
) (
  input logic                clk_four,
  input logic                reset_n,
  chess_clock_ctrl_if.master bus
);

  localparam int              CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  localparam int B_START = 0;
  localparam int B_RESET = 1;
  localparam int B_P1    = 2;
  localparam int B_P2    = 3;
`ifdef CHESS_PAUSE_EN
  localparam int B_PAUSE = 4;
  localparam int NBTN    = 5;
`else
  localparam int NBTN    = 4;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_P1 = 3'd1,
    RUN_P2 = 3'd2,
    OVER   = 3'd3
`ifdef CHESS_PAUSE_EN
    ,
    PAUSED = 3'd4
`endif
  } state_t;

  function automatic logic [MOVE_CNT_W-1:0] sat_inc(input logic [MOVE_CNT_W-1:0] v);
    return (&v) ? v : v + MOVE_CNT_W'(1);
  endfunction

  logic [NBTN-1:0]  btn_raw;
  logic [NBTN-1:0]  sync_p0;
  logic [NBTN-1:0]  sync_p1;
  logic [NBTN-1:0]  lvl_p2;
  logic [NBTN-1:0]  lvl_p3;
  logic [NBTN-1:0]  press;
  logic [CNT_W-1:0] deb_cnt [NBTN];

`ifdef CHESS_PAUSE_EN
  assign btn_raw = {bus.btn_pause, bus.btn_p2, bus.btn_p1, bus.btn_reset, bus.btn_start};
`else
  logic unused_pause;
  assign unused_pause = bus.btn_pause;
  assign btn_raw = {bus.btn_p2, bus.btn_p1, bus.btn_reset, bus.btn_start};
`endif

  // Stage p0/p1: synchronizer; p2: debounced level; p3: previous level for edge detect
  always_ff @(posedge clk_four or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      lvl_p2  <= '0;
      lvl_p3  <= '0;
      for (int i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      lvl_p3  <= lvl_p2;
      for (int i = 0; i < NBTN; i++) begin
        if (sync_p1[i] == lvl_p2[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_MAX) begin
          lvl_p2[i]  <= sync_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = lvl_p2 & ~lvl_p3;

  logic rst_ev, start_ev, p1_ev, p2_ev;
  assign rst_ev   = press[B_RESET];
  assign start_ev = press[B_START];
  assign p1_ev    = press[B_P1];
  assign p2_ev    = press[B_P2];
`ifdef CHESS_PAUSE_EN
  logic pause_ev;
  assign pause_ev = press[B_PAUSE];
`endif

  state_t                state_q, next_state;
  logic                  start_q, player_q, timer_reset_q, game_over_q;
  logic [1:0]            winner_q;
  logic [MOVE_CNT_W-1:0] move_cnt_q;
  logic                  start_d, player_d, timer_reset_d, game_over_d;
  logic [1:0]            winner_d;
  logic [MOVE_CNT_W-1:0] move_cnt_d;
  logic                  move_ok;

  // FSM state and registered outputs
  always_ff @(posedge clk_four or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      player_q      <= 1'b0;
      timer_reset_q <= 1'b1;
      game_over_q   <= 1'b0;
      winner_q      <= 2'b00;
      move_cnt_q    <= '0;
    end else begin
      state_q       <= next_state;
      start_q       <= start_d;
      player_q      <= player_d;
      timer_reset_q <= timer_reset_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      move_cnt_q    <= move_cnt_d;
    end
  end

  // Priority: reset press > active zero flag > pause press > move press
  always_comb begin
    next_state = state_q;
    if (rst_ev) begin
      next_state = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (start_ev) next_state = RUN_P1;
        RUN_P1: begin
          if (bus.zero1)    next_state = OVER;
`ifdef CHESS_PAUSE_EN
          else if (pause_ev) next_state = PAUSED;
`endif
          else if (p1_ev)   next_state = RUN_P2;
        end
        RUN_P2: begin
          if (bus.zero2)    next_state = OVER;
`ifdef CHESS_PAUSE_EN
          else if (pause_ev) next_state = PAUSED;
`endif
          else if (p2_ev)   next_state = RUN_P1;
        end
`ifdef CHESS_PAUSE_EN
        PAUSED: if (pause_ev) next_state = player_q ? RUN_P2 : RUN_P1;
`endif
        OVER:   next_state = OVER;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    move_ok       = ((state_q == RUN_P1) && (next_state == RUN_P2)) ||
                    ((state_q == RUN_P2) && (next_state == RUN_P1));
    start_d       = (next_state == RUN_P1) || (next_state == RUN_P2);
    game_over_d   = (next_state == OVER);
    timer_reset_d = rst_ev;
    player_d      = player_q;
    winner_d      = winner_q;
    move_cnt_d    = move_cnt_q;
    if (rst_ev) begin
      player_d   = 1'b0;
      winner_d   = 2'b00;
      move_cnt_d = '0;
    end else begin
      if (next_state == RUN_P2)      player_d = 1'b1;
      else if (next_state == RUN_P1) player_d = 1'b0;
      if ((state_q == RUN_P1) && (next_state == OVER)) winner_d = 2'b10;
      if ((state_q == RUN_P2) && (next_state == OVER)) winner_d = 2'b01;
      if (move_ok) move_cnt_d = sat_inc(move_cnt_q);
    end
  end

  assign bus.start       = start_q;
  assign bus.player      = player_q;
  assign bus.timer_reset = timer_reset_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;
  assign bus.move_count  = move_cnt_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Directed bench for chess_clock_ctrl with DEB_CYCLES=4 and an 8-bit move counter.
module tb_chess_clock_ctrl;

  localparam int DEB = 4;
  localparam int MW  = 8;

  localparam int ID_START = 0;
  localparam int ID_RESET = 1;
  localparam int ID_P1    = 2;
  localparam int ID_P2    = 3;
  localparam int ID_PAUSE = 4;

  logic clk_four = 1'b0;
  logic reset_n  = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  chess_clock_ctrl_if #(.MOVE_CNT_W(MW)) bif ();

  chess_clock_ctrl #(.DEB_CYCLES(DEB), .MOVE_CNT_W(MW)) dut (
    .clk_four (clk_four),
    .reset_n  (reset_n),
    .bus      (bif)
  );

  always #5 clk_four = ~clk_four;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_four);
      #1;
    end
  endtask

  task automatic set_btn(input int id, input logic v);
    case (id)
      ID_START: bif.btn_start = v;
      ID_RESET: bif.btn_reset = v;
      ID_P1:    bif.btn_p1    = v;
      ID_P2:    bif.btn_p2    = v;
      default:  bif.btn_pause = v;
    endcase
  endtask

  task automatic press_btn(input int id);
    set_btn(id, 1'b1);
    tick(8);
    set_btn(id, 1'b0);
    tick(8);
  endtask

  initial begin
    bif.btn_start = 0; bif.btn_reset = 0; bif.btn_p1 = 0; bif.btn_p2 = 0;
    bif.btn_pause = 0; bif.zero1 = 0; bif.zero2 = 0;

    #23;
    check_eq("rst_start",   bif.start, 0);
    check_eq("rst_player",  bif.player, 0);
    check_eq("rst_treset",  bif.timer_reset, 1);
    check_eq("rst_over",    bif.game_over, 0);
    check_eq("rst_winner",  bif.winner, 0);
    check_eq("rst_moves",   bif.move_count, 0);
    #4 reset_n = 1'b1;
    #1 check_eq("treset_held", bif.timer_reset, 1);
    tick(1);
    check_eq("treset_drop", bif.timer_reset, 0);

    // 3-cycle glitch must not be accepted
    bif.btn_start = 1; tick(3); bif.btn_start = 0;
    tick(10);
    check_eq("glitch_start", bif.start, 0);

    // Held start: outputs change exactly 7 cycles after the raw edge
    bif.btn_start = 1;
    tick(6);
    check_eq("start_early", bif.start, 0);
    tick(1);
    check_eq("start_at7",   bif.start, 1);
    check_eq("start_player", bif.player, 0);
    tick(3); bif.btn_start = 0; tick(8);

    press_btn(ID_P2);
    check_eq("p2_ign_player", bif.player, 0);
    check_eq("p2_ign_moves",  bif.move_count, 0);
    press_btn(ID_START);
    check_eq("start_ign", bif.start, 1);
    press_btn(ID_P1);
    check_eq("mv1_player", bif.player, 1);
    check_eq("mv1_moves",  bif.move_count, 1);
    press_btn(ID_P2);
    check_eq("mv2_player", bif.player, 0);
    check_eq("mv2_moves",  bif.move_count, 2);
    press_btn(ID_P1);
    check_eq("mv3_player", bif.player, 1);
    check_eq("mv3_moves",  bif.move_count, 3);

    // Inactive zero flag is ignored
    bif.zero1 = 1; tick(3);
    check_eq("z1_ign_over",  bif.game_over, 0);
    check_eq("z1_ign_start", bif.start, 1);
    bif.zero1 = 0;

    // zero2 together with the btn_p2 pulse: timeout wins
    bif.btn_p2 = 1;
    tick(6);
    bif.zero2 = 1;
    tick(1);
    check_eq("to_over",   bif.game_over, 1);
    check_eq("to_winner", bif.winner, 2'b01);
    check_eq("to_start",  bif.start, 0);
    check_eq("to_moves",  bif.move_count, 3);
    check_eq("to_player", bif.player, 1);
    tick(2); bif.btn_p2 = 0; tick(8);
    press_btn(ID_START);
    check_eq("over_hold", bif.game_over, 1);
    check_eq("over_start", bif.start, 0);

    // Reset press from OVER
    bif.btn_reset = 1;
    tick(6);
    check_eq("grst_early", bif.timer_reset, 0);
    tick(1);
    check_eq("grst_treset", bif.timer_reset, 1);
    check_eq("grst_over",   bif.game_over, 0);
    check_eq("grst_winner", bif.winner, 0);
    check_eq("grst_moves",  bif.move_count, 0);
    check_eq("grst_start",  bif.start, 0);
    bif.zero2 = 0;
    tick(1);
    check_eq("grst_pulse1", bif.timer_reset, 0);
    tick(2); bif.btn_reset = 0; tick(8);
    press_btn(ID_START);
    check_eq("restart_start",  bif.start, 1);
    check_eq("restart_player", bif.player, 0);

    // Both zero flags in RUN_P1: player 1 loses
    bif.zero1 = 1; bif.zero2 = 1;
    tick(1);
    check_eq("both_over",   bif.game_over, 1);
    check_eq("both_winner", bif.winner, 2'b10);
    press_btn(ID_RESET);
    bif.zero1 = 0; bif.zero2 = 0;
    check_eq("both_rst", bif.winner, 0);
    press_btn(ID_START);

    // Saturation of move_count
    for (int i = 0; i < 255; i++) press_btn((i % 2 == 0) ? ID_P1 : ID_P2);
    check_eq("sat255_moves",  bif.move_count, 255);
    check_eq("sat255_player", bif.player, 1);
    press_btn(ID_P2);
    check_eq("sat256_moves",  bif.move_count, 255);
    check_eq("sat256_player", bif.player, 0);
    press_btn(ID_P1);
    check_eq("sat257_moves",  bif.move_count, 255);
    check_eq("sat257_player", bif.player, 1);

`ifdef CHESS_PAUSE_EN
    press_btn(ID_PAUSE);
    check_eq("pause_start",  bif.start, 0);
    check_eq("pause_player", bif.player, 1);
    press_btn(ID_P2);
    check_eq("pause_p2_ign", bif.player, 1);
    bif.zero2 = 1; tick(2);
    check_eq("pause_z2_ign", bif.game_over, 0);
    bif.zero2 = 0;
    press_btn(ID_PAUSE);
    check_eq("resume_start",  bif.start, 1);
    check_eq("resume_player", bif.player, 1);
`else
    press_btn(ID_PAUSE);
    check_eq("nopause_start",  bif.start, 1);
    check_eq("nopause_player", bif.player, 1);
`endif
    press_btn(ID_P2);
    check_eq("final_player", bif.player, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
